// File: rtl/triangulo_pkg.sv
// rtl/triangulo_pkg.sv - shared types and widths for the triangle scan generator
// Contents:
//   COORD_W   coordinate width (12)
//   CONT_W    transfer counter width (25, holds up to 2^24 points)
//   coord_t   unsigned screen coordinate
//   estado_t  scan FSM states
//   clamp_max clamps a coordinate to an upper limit

package triangulo_pkg;
   localparam int COORD_W = 12;
   localparam int CONT_W  = 25;

   typedef logic [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CAIXA = 2'd1,
      VARRE = 2'd2,
      FIM   = 2'd3
   } estado_t;

   function automatic coord_t clamp_max(input coord_t v, input coord_t lim);
      return (v > lim) ? lim : v;
   endfunction
endpackage

// File: rtl/minmax3.sv
// rtl/minmax3.sv - combinational minimum and maximum of three coordinates
// Ports:
//   a, b, c  in   coordinates to compare (unsigned)
//   mn       out  smallest of a, b, c
//   mx       out  largest of a, b, c

module minmax3
   import triangulo_pkg::*;
(
   input  coord_t a,
   input  coord_t b,
   input  coord_t c,
   output coord_t mn,
   output coord_t mx
);
   coord_t min_ab;
   coord_t max_ab;

   always_comb begin
      min_ab = (a < b) ? a : b;
      max_ab = (a > b) ? a : b;
      mn     = (min_ab < c) ? min_ab : c;
      mx     = (max_ab > c) ? max_ab : c;
   end
endmodule

// File: rtl/varredura_triangulo.sv
// rtl/varredura_triangulo.sv - bounding-box raster scan generator for a triangle
// Latches three vertices on start/pronto, computes their inclusive bounding
// box, then streams every point of the box in raster order over a
// valid/ready interface while presenting the latched vertices.
// Optional feature macro: VARREDURA_CLIP_EN (clip the box to LARGURA x ALTURA).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start / pronto              vertex handshake (accept on start && pronto)
//   v1x..v3y                    vertex inputs, sampled on accept
//   pt1X..pt3Y                  latched vertices
//   ptX, ptY                    current candidate point
//   pt_valid / pt_ready         point handshake
//   pt_last                     current point is the last of the box
//   fim                         one-cycle pulse at the end of a scan
//   contagem                    points transferred in the current/last scan

module varredura_triangulo
   import triangulo_pkg::*;
#(
   parameter int LARGURA = 640,
   parameter int ALTURA  = 480
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              pronto,
   input  logic [11:0]       v1x,
   input  logic [11:0]       v1y,
   input  logic [11:0]       v2x,
   input  logic [11:0]       v2y,
   input  logic [11:0]       v3x,
   input  logic [11:0]       v3y,
   output logic [11:0]       pt1X,
   output logic [11:0]       pt1Y,
   output logic [11:0]       pt2X,
   output logic [11:0]       pt2Y,
   output logic [11:0]       pt3X,
   output logic [11:0]       pt3Y,
   output logic [11:0]       ptX,
   output logic [11:0]       ptY,
   output logic              pt_valid,
   input  logic              pt_ready,
   output logic              pt_last,
   output logic              fim,
   output logic [CONT_W-1:0] contagem
);
   estado_t estado_q, estado_d;
   coord_t  p1x_q, p1y_q, p2x_q, p2y_q, p3x_q, p3y_q;
   coord_t  p1x_d, p1y_d, p2x_d, p2y_d, p3x_d, p3y_d;
   coord_t  xmin_q, xmax_q, ymin_q, ymax_q;
   coord_t  xmin_d, xmax_d, ymin_d, ymax_d;
   coord_t  pt_x_q, pt_y_q, pt_x_d, pt_y_d;
   logic    pronto_q, pronto_d;
   logic    pt_valid_q, pt_valid_d;
   logic    pt_last_q, pt_last_d;
   logic    fim_q, fim_d;
   logic [CONT_W-1:0] contagem_q, contagem_d;

   coord_t  bx_min, bx_max, by_min, by_max;
   coord_t  x_hi, y_hi;
   logic    vazio;

   minmax3 u_mm_x (.a(p1x_q), .b(p2x_q), .c(p3x_q), .mn(bx_min), .mx(bx_max));
   minmax3 u_mm_y (.a(p1y_q), .b(p2y_q), .c(p3y_q), .mn(by_min), .mx(by_max));

`ifdef VARREDURA_CLIP_EN
   localparam coord_t X_LIM = coord_t'(LARGURA - 1);
   localparam coord_t Y_LIM = coord_t'(ALTURA - 1);

   always_comb begin
      x_hi  = clamp_max(bx_max, X_LIM);
      y_hi  = clamp_max(by_max, Y_LIM);
      // Box starts off-screen: nothing to scan at all.
      vazio = (bx_min > X_LIM) || (by_min > Y_LIM);
   end
`else
   logic unused_dims;
   assign unused_dims = (LARGURA != 0) ^ (ALTURA != 0);

   always_comb begin
      x_hi  = bx_max;
      y_hi  = by_max;
      vazio = 1'b0;
   end
`endif

   always_comb begin
      estado_d   = estado_q;
      p1x_d      = p1x_q;
      p1y_d      = p1y_q;
      p2x_d      = p2x_q;
      p2y_d      = p2y_q;
      p3x_d      = p3x_q;
      p3y_d      = p3y_q;
      xmin_d     = xmin_q;
      xmax_d     = xmax_q;
      ymin_d     = ymin_q;
      ymax_d     = ymax_q;
      pt_x_d     = pt_x_q;
      pt_y_d     = pt_y_q;
      pt_valid_d = pt_valid_q;
      pt_last_d  = pt_last_q;
      contagem_d = contagem_q;

      unique case (estado_q)
         IDLE: begin
            // pronto_q is high only in IDLE, so it alone qualifies the accept.
            if (start && pronto_q) begin
               p1x_d      = v1x;
               p1y_d      = v1y;
               p2x_d      = v2x;
               p2y_d      = v2y;
               p3x_d      = v3x;
               p3y_d      = v3y;
               contagem_d = '0;
               estado_d   = CAIXA;
            end
         end
         CAIXA: begin
            xmin_d = bx_min;
            xmax_d = x_hi;
            ymin_d = by_min;
            ymax_d = y_hi;
            pt_x_d = bx_min;
            pt_y_d = by_min;
            if (vazio) begin
               estado_d = FIM;
            end else begin
               pt_valid_d = 1'b1;
               pt_last_d  = (bx_min == x_hi) && (by_min == y_hi);
               estado_d   = VARRE;
            end
         end
         VARRE: begin
            if (pt_ready) begin
               contagem_d = contagem_q + CONT_W'(1);
               if (pt_x_q < xmax_q) begin
                  pt_x_d    = pt_x_q + 12'd1;
                  pt_last_d = ((pt_x_q + 12'd1) == xmax_q) && (pt_y_q == ymax_q);
               end else if (pt_y_q < ymax_q) begin
                  pt_x_d    = xmin_q;
                  pt_y_d    = pt_y_q + 12'd1;
                  pt_last_d = (xmin_q == xmax_q) && ((pt_y_q + 12'd1) == ymax_q);
               end else begin
                  pt_valid_d = 1'b0;
                  pt_last_d  = 1'b0;
                  estado_d   = FIM;
               end
            end
         end
         FIM: begin
            estado_d = IDLE;
         end
         default: begin
            estado_d = IDLE;
         end
      endcase

      // Registered flags derived from the next state keep outputs glitch-free.
      pronto_d = (estado_d == IDLE);
      fim_d    = (estado_d == FIM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q   <= IDLE;
         p1x_q      <= '0;
         p1y_q      <= '0;
         p2x_q      <= '0;
         p2y_q      <= '0;
         p3x_q      <= '0;
         p3y_q      <= '0;
         xmin_q     <= '0;
         xmax_q     <= '0;
         ymin_q     <= '0;
         ymax_q     <= '0;
         pt_x_q     <= '0;
         pt_y_q     <= '0;
         pronto_q   <= 1'b0;
         pt_valid_q <= 1'b0;
         pt_last_q  <= 1'b0;
         fim_q      <= 1'b0;
         contagem_q <= '0;
      end else begin
         estado_q   <= estado_d;
         p1x_q      <= p1x_d;
         p1y_q      <= p1y_d;
         p2x_q      <= p2x_d;
         p2y_q      <= p2y_d;
         p3x_q      <= p3x_d;
         p3y_q      <= p3y_d;
         xmin_q     <= xmin_d;
         xmax_q     <= xmax_d;
         ymin_q     <= ymin_d;
         ymax_q     <= ymax_d;
         pt_x_q     <= pt_x_d;
         pt_y_q     <= pt_y_d;
         pronto_q   <= pronto_d;
         pt_valid_q <= pt_valid_d;
         pt_last_q  <= pt_last_d;
         fim_q      <= fim_d;
         contagem_q <= contagem_d;
      end
   end

   assign pronto   = pronto_q;
   assign pt1X     = p1x_q;
   assign pt1Y     = p1y_q;
   assign pt2X     = p2x_q;
   assign pt2Y     = p2y_q;
   assign pt3X     = p3x_q;
   assign pt3Y     = p3y_q;
   assign ptX      = pt_x_q;
   assign ptY      = pt_y_q;
   assign pt_valid = pt_valid_q;
   assign pt_last  = pt_last_q;
   assign fim      = fim_q;
   assign contagem = contagem_q;
endmodule

// File: tb/tb_varredura_triangulo.sv
// tb/tb_varredura_triangulo.sv - directed self-checking bench for varredura_triangulo
// Build with VARREDURA_CLIP_EN defined to exercise clipping at LARGURA=20.

module tb_varredura_triangulo;
`ifdef VARREDURA_CLIP_EN
   localparam int L_W   = 20;
   localparam int XA_HI = 19;
`else
   localparam int L_W   = 640;
   localparam int XA_HI = 32;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        pt_ready = 1'b0;
   logic [11:0] v1x = '0, v1y = '0, v2x = '0, v2y = '0, v3x = '0, v3y = '0;
   logic        pronto, pt_valid, pt_last, fim;
   logic [11:0] pt1X, pt1Y, pt2X, pt2Y, pt3X, pt3Y, ptX, ptY;
   logic [24:0] contagem;

   int tests = 0;
   int fails = 0;

   varredura_triangulo #(.LARGURA(L_W), .ALTURA(480)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pronto(pronto),
      .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y), .v3x(v3x), .v3y(v3y),
      .pt1X(pt1X), .pt1Y(pt1Y), .pt2X(pt2X), .pt2Y(pt2Y), .pt3X(pt3X), .pt3Y(pt3Y),
      .ptX(ptX), .ptY(ptY), .pt_valid(pt_valid), .pt_ready(pt_ready),
      .pt_last(pt_last), .fim(fim), .contagem(contagem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input string tag, input int ax, ay, bx, by, cx, cy);
      int k;
      k = 0;
      while (pronto !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      chk({tag, " pronto_before"}, {31'd0, pronto}, 32'd1);
      v1x = 12'(ax); v1y = 12'(ay);
      v2x = 12'(bx); v2y = 12'(by);
      v3x = 12'(cx); v3y = 12'(cy);
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, " pronto_after_accept"}, {31'd0, pronto}, 32'd0);
      chk({tag, " valid_in_caixa"}, {31'd0, pt_valid}, 32'd0);
   endtask

   // Walks the expected raster of box [x0..x1]x[y0..y1] against the DUT.
   // inj_at >= 0 pulses start with other vertices after that many transfers.
   // abort_at stops consuming after that many transfers (no end checks).
   task automatic scan(input string tag, input int x0, x1, y0, y1,
                       input bit rnd, input int inj_at, input int abort_at);
      int  ex, ey, n, bad, stall_bad, cyc, fx, fy, lx, ly, total;
      bit  done, stalled, got_first, llast;
      logic [11:0] hx, hy;
      total = (x1 - x0 + 1) * (y1 - y0 + 1);
      ex = x0; ey = y0; n = 0; bad = 0; stall_bad = 0; cyc = 0;
      fx = -1; fy = -1; lx = -1; ly = -1; llast = 1'b0;
      done = 1'b0; stalled = 1'b0; got_first = 1'b0; hx = '0; hy = '0;
      while (!done && cyc < 30000 && n < abort_at) begin
         pt_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         start = 1'b0;
         if (inj_at >= 0 && n == inj_at && pt_valid === 1'b1) begin
            start = 1'b1;
            v1x = 12'd100; v1y = 12'd101; v2x = 12'd102;
            v2y = 12'd103; v3x = 12'd104; v3y = 12'd105;
         end
         if (stalled && (pt_valid !== 1'b1 || ptX !== hx || ptY !== hy))
            stall_bad++;
         if (pt_valid === 1'b1) begin
            if (!got_first) begin
               fx = int'(ptX); fy = int'(ptY); got_first = 1'b1;
            end
            if (ptX !== 12'(ex) || ptY !== 12'(ey) ||
                pt_last !== ((ex == x1) && (ey == y1)))
               bad++;
            stalled = !pt_ready;
            hx = ptX; hy = ptY;
            if (pt_ready) begin
               n++;
               lx = int'(ptX); ly = int'(ptY); llast = pt_last;
               if (ex < x1) ex++;
               else if (ey < y1) begin ex = x0; ey++; end
               else done = 1'b1;
            end
         end else begin
            stalled = 1'b0;
         end
         step();
         cyc++;
      end
      start = 1'b0;
      pt_ready = 1'b0;
      chk({tag, " sequence_errors"}, bad, 0);
      chk({tag, " stall_errors"}, stall_bad, 0);
      chk({tag, " first_x"}, fx, x0);
      chk({tag, " first_y"}, fy, y0);
      if (abort_at > total) begin
         chk({tag, " completed"}, {31'd0, done}, 32'd1);
         chk({tag, " transfers"}, n, total);
         chk({tag, " last_x"}, lx, x1);
         chk({tag, " last_y"}, ly, y1);
         chk({tag, " last_flag"}, {31'd0, llast}, 32'd1);
         chk({tag, " fim_pulse"}, {31'd0, fim}, 32'd1);
         chk({tag, " contagem"}, {7'd0, contagem}, total);
         chk({tag, " valid_after"}, {31'd0, pt_valid}, 32'd0);
         step();
         chk({tag, " fim_clears"}, {31'd0, fim}, 32'd0);
         chk({tag, " pronto_back"}, {31'd0, pronto}, 32'd1);
         chk({tag, " contagem_holds"}, {7'd0, contagem}, total);
      end else begin
         chk({tag, " aborted_transfers"}, n, abort_at);
         chk({tag, " contagem_at_abort"}, {7'd0, contagem}, abort_at);
      end
   endtask

   initial begin
      int fim_seen, valid_seen;

      // Reset state (several edges with reset held low).
      step();
      step();
      chk("rst pronto", {31'd0, pronto}, 32'd0);
      chk("rst pt_valid", {31'd0, pt_valid}, 32'd0);
      chk("rst pt_last", {31'd0, pt_last}, 32'd0);
      chk("rst fim", {31'd0, fim}, 32'd0);
      chk("rst contagem", {7'd0, contagem}, 32'd0);
      chk("rst ptX", {20'd0, ptX}, 32'd0);
      chk("rst ptY", {20'd0, ptY}, 32'd0);
      chk("rst pt1X", {20'd0, pt1X}, 32'd0);
      chk("rst pt3Y", {20'd0, pt3Y}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("rel pronto", {31'd0, pronto}, 32'd1);

      // Main triangle, ready always high.
      accept("triA", 13, 13, 32, 10, 16, 30);
      chk("triA pt1X", {20'd0, pt1X}, 32'd13);
      chk("triA pt2Y", {20'd0, pt2Y}, 32'd10);
      chk("triA pt3Y", {20'd0, pt3Y}, 32'd30);
      scan("triA", 13, XA_HI, 10, 30, 1'b0, -1, 1 << 30);

      // Fully coincident vertices: exactly one point.
      accept("pt55", 5, 5, 5, 5, 5, 5);
      scan("pt55", 5, 5, 5, 5, 1'b0, -1, 1 << 30);

      // Backpressure with pseudo-random ready.
      accept("triR", 13, 13, 32, 10, 16, 30);
      scan("triR", 13, XA_HI, 10, 30, 1'b1, -1, 1 << 30);

      // start pulsed mid-scan must be ignored.
      accept("triS", 13, 13, 32, 10, 16, 30);
      scan("triS", 13, XA_HI, 10, 30, 1'b0, 10, 1 << 30);
      chk("triS pt1X", {20'd0, pt1X}, 32'd13);
      chk("triS pt1Y", {20'd0, pt1Y}, 32'd13);
      chk("triS pt2X", {20'd0, pt2X}, 32'd32);
      chk("triS pt2Y", {20'd0, pt2Y}, 32'd10);
      chk("triS pt3X", {20'd0, pt3X}, 32'd16);
      chk("triS pt3Y", {20'd0, pt3Y}, 32'd30);

      // Reset after 50 transfers aborts the scan.
      accept("triX", 13, 13, 32, 10, 16, 30);
      scan("triX", 13, XA_HI, 10, 30, 1'b0, -1, 50);
      rst_n = 1'b0;
      #1;
      chk("abort pt_valid", {31'd0, pt_valid}, 32'd0);
      chk("abort contagem", {7'd0, contagem}, 32'd0);
      chk("abort pronto", {31'd0, pronto}, 32'd0);
      fim_seen = 0;
      step();
      if (fim === 1'b1) fim_seen++;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (fim === 1'b1) fim_seen++;
      end
      chk("abort no_fim", fim_seen, 0);
      chk("abort pronto_back", {31'd0, pronto}, 32'd1);

      // Fresh scan after the abort.
      accept("triN", 13, 13, 32, 10, 16, 30);
      scan("triN", 13, XA_HI, 10, 30, 1'b0, -1, 1 << 30);

`ifdef VARREDURA_CLIP_EN
      // Box entirely right of the screen: no points at all.
      accept("off", 25, 5, 30, 6, 40, 9);
      valid_seen = 0;
      fim_seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (pt_valid === 1'b1) valid_seen++;
         if (fim === 1'b1) fim_seen++;
         step();
      end
      chk("off valid_seen", valid_seen, 0);
      chk("off fim_seen", fim_seen, 1);
      chk("off contagem", {7'd0, contagem}, 32'd0);
      chk("off pronto", {31'd0, pronto}, 32'd1);
`else
      valid_seen = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
